axis_width_resizer: RTL and testbench
=====================================

Name: axis_width_resizer

Overview:
- Generic AXI4-Stream width converter for any integer ratio between input and output widths, in both directions, with packet-aware tlast/tkeep handling.
- Successor to the fixed 512/256 converter. Sits between the memory/network stream interfaces and operator pipelines of differing widths.
- Sustains full throughput on the narrow side.
- Output is registered: no combinational path from in.tvalid/in.tdata to out.

Parameters:
- IN_WIDTH, 512, input tdata width in bits; multiple of 8.
- OUT_WIDTH, 256, output tdata width in bits; multiple of 8.
- Derived constants:
  - RATIO = max(IN,OUT)/min(IN,OUT). Elaboration assertion: exact integer, 1 <= RATIO <= 16.
  - NARROW = min(IN_WIDTH, OUT_WIDTH).
  - NKEEP = NARROW/8.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- in  AXI4S.s  IN_WIDTH  input stream: tdata, tkeep[IN_WIDTH/8], tlast, tvalid, tready.
- out  AXI4S.m  OUT_WIDTH  output stream: same signal set at OUT_WIDTH.

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
  - While rst_n low: out.tvalid=0, out.tdata=0, out.tkeep=0, out.tlast=0, in.tready=0.
  - All counters and valid flags clear.
  - A reset mid-packet discards all partial state. No beat is emitted after reset until new input arrives.
- AXI rules:
  - out.tvalid, once high, holds until out.tready. tdata/tkeep/tlast stay stable while out.tvalid && !out.tready.
  - in.tready never depends combinationally on in.tvalid.
- Slice ordering: little-endian. Slice k occupies bits [k*NARROW +: NARROW]. Slice 0 is transferred first.
- RATIO==1: one-stage register slice. Latency 1 cycle, full throughput, fields passed unchanged.
- Upsize (OUT > IN):
  - Accumulator holds RATIO slices. Counter idx runs 0..RATIO-1. Each accepted input beat writes slice idx.
  - Word is complete when idx==RATIO-1 or the beat has tlast.
  - On completion, the word moves to the output register; idx resets to 0. Unfilled slices get data=0, keep=0. out.tlast = the input tlast.
  - in.tready = !(completing_beat_possible && out.tvalid && !out.tready). The accumulator stalls only when the output register is occupied and blocked.
  - Latency: 1 cycle from the completing input beat to out.tvalid.
  - Throughput: 1 output per RATIO input beats, no bubbles.
  - A tlast beat arriving at idx 0 yields a word with only slice 0 kept.
- Downsize (IN > OUT):
  - Holding register stores one input word with hold_valid; slice counter sidx runs 0..RATIO-1.
  - out.tdata/tkeep = slice sidx of the held word.
  - Final slice:
    - Non-tlast words: sidx==RATIO-1.
    - tlast words: the highest slice with any keep bit set. If the whole word's keep is 0, slice 0.
  - Trailing all-zero-keep slices of a tlast word are never emitted. out.tlast=1 only on the final slice of a tlast word.
  - Mid-packet slices are emitted even if their keep is 0.
  - in.tready = !hold_valid || (out.tready && final slice). This allows back-to-back words with no bubble.
  - Latency: 1 cycle from input accept to the first slice valid.
- Simultaneous events:
  - Accept a new input and drain the output in the same cycle: both take effect.
  - Counters update only on their own handshake.

Decomposition:
- Package axis_width_pkg:
  - function ratio(in_w, out_w).
  - function last_keep_slice(keep, ratio, nkeep) returning the highest nonzero slice index.
  - Constant MAX_RATIO=16.
- Sub-module axis_reg_slice #(WIDTH):
  - One-entry registered stage with valid/ready.
  - Used as the output register in upsize mode, as the holding register in downsize mode, and directly for RATIO==1.

Test Plan:
- Downsize: IN=512, OUT=128, 3 back-to-back full-keep words, last with tlast, out.tready=1 -> 12 output beats with no bubbles. Slices are in order 0..3 per word. tlast only on beat 12. in.tready is high on cycles 4 and 8 of the drain.
- Downsize tlast trim: IN=512, OUT=128, one word with tlast and tkeep=64'h0000_0000_00FF_FFFF -> exactly 2 beats, keeps 16'hFFFF then 16'h00FF, second beat has tlast=1.
- Upsize partial: IN=64, OUT=256, 6 beats, 6th with tlast -> 2 output words.
  - Word 1: tkeep all ones, tlast=0.
  - Word 2: slices 0–1 carry beats 5–6, tkeep=32'h0000_FFFF, upper data 0, tlast=1.
- Backpressure: upsize 256→512 with random out.tready (50%) and random in.tvalid over 1000 packets of random length -> scoreboard byte stream and tlast positions match exactly; tdata/tkeep/tlast remain stable during every stall.
- Reset mid-packet: downsize 512→256, assert rst_n=0 after the first slice handshake -> next cycle out.tvalid=0 and in.tready=0. After release, a new word emits from slice 0 and no stale slice appears.
- RATIO==1: IN=OUT=256, 100 random beats -> identical sequence out, 1-cycle latency, full throughput with out.tready=1.

Source files
------------

// File: rtl/axis_width_pkg.sv
// Shared constants and elaboration helpers for the AXI4-Stream width resizer.
package axis_width_pkg;

  localparam int unsigned MAX_RATIO  = 16;
  // Widest keep vector the helper accepts (an 8192-bit bus).
  localparam int unsigned MAX_KEEP_W = 1024;

  function automatic int unsigned ratio(int unsigned in_w, int unsigned out_w);
    return (in_w > out_w) ? in_w / out_w : out_w / in_w;
  endfunction

  function automatic int unsigned last_keep_slice(logic [MAX_KEEP_W-1:0] keep,
                                                  int unsigned ratio_n, int unsigned nkeep);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
      if (i < ratio_n * nkeep && keep[i]) res = i / nkeep;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_width_resizer_if.sv
// AXI4-Stream bundle; m drives the stream, s receives it.
interface AXI4S #(
  parameter int unsigned WIDTH = 256
);
  logic [WIDTH-1:0]   tdata;
  logic [WIDTH/8-1:0] tkeep;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport m (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport s (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_reg_slice.sv
// One-entry registered valid/ready stage; accepts a new entry while the old one drains.
module axis_reg_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/axis_width_resizer.sv
// AXI4-Stream width converter for any integer width ratio up to MAX_RATIO, either direction.
// All outputs come from registers; tlast/tkeep are packet-aware.
module axis_width_resizer
  import axis_width_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 512,
  parameter int unsigned OUT_WIDTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  AXI4S.s      in,
  AXI4S.m      out
);

  localparam int unsigned RATIO    = ratio(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned NARROW   = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int unsigned NKEEP    = NARROW / 8;
  localparam int unsigned IN_KEEP  = IN_WIDTH / 8;
  localparam int unsigned OUT_KEEP = OUT_WIDTH / 8;
  localparam int unsigned IDXW     = (RATIO > 1) ? $clog2(RATIO) : 1;

  if ((IN_WIDTH % 8 != 0) || (OUT_WIDTH % 8 != 0) || (NARROW == 0) ||
      (RATIO * NARROW != ((IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH)) ||
      (RATIO < 1) || (RATIO > MAX_RATIO)) begin : g_bad_params
    $fatal(1, "axis_width_resizer: widths must be byte multiples with integer ratio 1..16");
  end

  if (RATIO == 1) begin : g_pass
    localparam int unsigned W = IN_WIDTH + IN_KEEP + 1;
    logic [W-1:0] slice_data;
    logic         slice_valid, slice_ready;

    axis_reg_slice #(.WIDTH(W)) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in.tvalid),
      .in_ready_o (slice_ready),
      .in_data_i  ({in.tlast, in.tkeep, in.tdata}),
      .out_valid_o(slice_valid),
      .out_ready_i(out.tready),
      .out_data_o (slice_data)
    );

    assign in.tready  = slice_ready && rst_n;
    assign out.tvalid = slice_valid && rst_n;
    assign {out.tlast, out.tkeep, out.tdata} = slice_data;

  end else if (OUT_WIDTH > IN_WIDTH) begin : g_up
    localparam int unsigned W = OUT_WIDTH + OUT_KEEP + 1;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d, word_data;
    logic [OUT_KEEP-1:0]  acc_keep_q, acc_keep_d, word_keep;
    logic [W-1:0]         slice_data;
    logic                 slice_valid, slice_ready, completing, accept;

    // The accumulator is cleared on completion, so unfilled upper slices are already zero.
    assign completing = (idx_q == IDXW'(RATIO - 1)) || in.tlast;
    assign in.tready  = (slice_ready || !completing) && rst_n;
    assign accept     = in.tvalid && in.tready;

    always_comb begin
      word_data = acc_data_q;
      word_keep = acc_keep_q;
      for (int k = 0; k < RATIO; k++) begin
        if (idx_q == IDXW'(k)) begin
          word_data[k*NARROW +: NARROW] = in.tdata;
          word_keep[k*NKEEP +: NKEEP]   = in.tkeep;
        end
      end
    end

    always_comb begin
      idx_d      = idx_q;
      acc_data_d = acc_data_q;
      acc_keep_d = acc_keep_q;
      if (accept) begin
        if (completing) begin
          idx_d      = '0;
          acc_data_d = '0;
          acc_keep_d = '0;
        end else begin
          idx_d      = idx_q + 1'b1;
          acc_data_d = word_data;
          acc_keep_d = word_keep;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        idx_q      <= '0;
        acc_data_q <= '0;
        acc_keep_q <= '0;
      end else begin
        idx_q      <= idx_d;
        acc_data_q <= acc_data_d;
        acc_keep_q <= acc_keep_d;
      end
    end

    axis_reg_slice #(.WIDTH(W)) u_out (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in.tvalid && completing),
      .in_ready_o (slice_ready),
      .in_data_i  ({in.tlast, word_keep, word_data}),
      .out_valid_o(slice_valid),
      .out_ready_i(out.tready),
      .out_data_o (slice_data)
    );

    assign out.tvalid = slice_valid && rst_n;
    assign {out.tlast, out.tkeep, out.tdata} = slice_data;

  end else begin : g_down
    localparam int unsigned W = IN_WIDTH + IN_KEEP + 1;
    logic [IDXW-1:0]     sidx_q, sidx_d;
    logic [W-1:0]        hold_data;
    logic [IN_WIDTH-1:0] hold_word;
    logic [IN_KEEP-1:0]  hold_keep;
    logic                hold_last, hold_valid, hold_ready, final_slice;
    logic [NARROW-1:0]   slice_tdata;
    logic [NKEEP-1:0]    slice_tkeep;
    logic [IDXW-1:0]     last_idx;

    assign {hold_last, hold_keep, hold_word} = hold_data;
    // Trailing slices of a tlast word with no kept bytes are skipped.
    assign last_idx    = IDXW'(last_keep_slice(MAX_KEEP_W'(hold_keep), RATIO, NKEEP));
    assign final_slice = hold_last ? (sidx_q == last_idx) : (sidx_q == IDXW'(RATIO - 1));

    axis_reg_slice #(.WIDTH(W)) u_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in.tvalid),
      .in_ready_o (hold_ready),
      .in_data_i  ({in.tlast, in.tkeep, in.tdata}),
      .out_valid_o(hold_valid),
      .out_ready_i(out.tready && final_slice),
      .out_data_o (hold_data)
    );

    always_comb begin
      slice_tdata = '0;
      slice_tkeep = '0;
      for (int k = 0; k < RATIO; k++) begin
        if (sidx_q == IDXW'(k)) begin
          slice_tdata = hold_word[k*NARROW +: NARROW];
          slice_tkeep = hold_keep[k*NKEEP +: NKEEP];
        end
      end
    end

    always_comb begin
      sidx_d = sidx_q;
      if (hold_valid && out.tready) sidx_d = final_slice ? '0 : sidx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) sidx_q <= '0;
      else        sidx_q <= sidx_d;
    end

    assign in.tready  = hold_ready && rst_n;
    assign out.tvalid = hold_valid && rst_n;
    assign out.tdata  = slice_tdata;
    assign out.tkeep  = slice_tkeep;
    assign out.tlast  = hold_last && final_slice;
  end

endmodule

// File: tb/tb_axis_width_resizer.sv
// Directed bench: downsize 512->128, upsize 64->256 and pass-through 256->256 instances.
module tb_axis_width_resizer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  AXI4S #(.WIDTH(512)) dn_in ();
  AXI4S #(.WIDTH(128)) dn_out ();
  AXI4S #(.WIDTH(64))  up_in ();
  AXI4S #(.WIDTH(256)) up_out ();
  AXI4S #(.WIDTH(256)) p1_in ();
  AXI4S #(.WIDTH(256)) p1_out ();

  axis_width_resizer #(.IN_WIDTH(512), .OUT_WIDTH(128)) u_dn (
    .clk(clk), .rst_n(rst_n), .in(dn_in), .out(dn_out));
  axis_width_resizer #(.IN_WIDTH(64), .OUT_WIDTH(256)) u_up (
    .clk(clk), .rst_n(rst_n), .in(up_in), .out(up_out));
  axis_width_resizer #(.IN_WIDTH(256), .OUT_WIDTH(256)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in(p1_in), .out(p1_out));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] dword(input int w);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'(w * 64 + i);
    return r;
  endfunction

  function automatic logic [63:0] bdat(input int k);
    return 64'(k + 1) * 64'h0101_0101_0101_0101;
  endfunction

  logic [511:0] wd;
  logic [288:0] bp_exp [3];
  logic [288:0] p1_exp [100];
  logic [289:0] prev;
  logic         stalled;
  logic [15:0]  vpat = 16'b1011_0111_1101_1110;
  logic [15:0]  rpat = 16'b0110_1011_0011_1101;
  int           widx, w, s, bi, oi;

  initial begin
    rst_n = 1'b0;
    dn_in.tvalid = 0; dn_in.tdata = '0; dn_in.tkeep = '0; dn_in.tlast = 0; dn_out.tready = 0;
    up_in.tvalid = 0; up_in.tdata = '0; up_in.tkeep = '0; up_in.tlast = 0; up_out.tready = 0;
    p1_in.tvalid = 0; p1_in.tdata = '0; p1_in.tkeep = '0; p1_in.tlast = 0; p1_out.tready = 0;
    cyc(); cyc();
    chk("rst_dn_tvalid", dn_out.tvalid, 0);
    chk("rst_dn_out", {dn_out.tlast, dn_out.tkeep, dn_out.tdata}, 0);
    chk("rst_dn_tready", dn_in.tready, 0);
    chk("rst_up_tvalid", up_out.tvalid, 0);
    chk("rst_up_tready", up_in.tready, 0);
    rst_n = 1'b1;
    cyc();

    // Downsize: three back-to-back full words, tlast on the third.
    dn_out.tready = 1;
    for (int c = 0; c <= 13; c++) begin
      widx = (c == 0) ? 0 : (c + 3) / 4;
      dn_in.tvalid = (widx < 3);
      dn_in.tdata  = dword(widx);
      dn_in.tkeep  = '1;
      dn_in.tlast  = (widx == 2);
      #1;
      if (c == 0) chk("dn_idle", dn_out.tvalid, 0);
      else if (c <= 12) begin
        w = (c - 1) / 4;
        s = (c - 1) % 4;
        wd = dword(w);
        chk("dn_tvalid", dn_out.tvalid, 1);
        chk("dn_tdata", dn_out.tdata, wd[s*128 +: 128]);
        chk("dn_tkeep", dn_out.tkeep, 16'hFFFF);
        chk("dn_tlast", dn_out.tlast, c == 12);
      end else chk("dn_drained", dn_out.tvalid, 0);
      chk("dn_in_tready", dn_in.tready, (c == 0 || c == 4 || c == 8 || c >= 12));
      cyc();
    end

    // Downsize tlast trim: 24 kept bytes -> two slices.
    dn_in.tvalid = 1; dn_in.tdata = dword(3); dn_in.tlast = 1;
    dn_in.tkeep = 64'h0000_0000_00FF_FFFF;
    cyc();
    dn_in.tvalid = 0;
    #1;
    wd = dword(3);
    chk("trim_v0", dn_out.tvalid, 1);
    chk("trim_keep0", dn_out.tkeep, 16'hFFFF);
    chk("trim_data0", dn_out.tdata, wd[127:0]);
    chk("trim_last0", dn_out.tlast, 0);
    cyc();
    chk("trim_v1", dn_out.tvalid, 1);
    chk("trim_keep1", dn_out.tkeep, 16'h00FF);
    chk("trim_data1", dn_out.tdata, wd[255:128]);
    chk("trim_last1", dn_out.tlast, 1);
    chk("trim_tready1", dn_in.tready, 1);
    cyc();
    chk("trim_done", dn_out.tvalid, 0);

    // Reset mid-packet on the downsizer.
    dn_in.tvalid = 1; dn_in.tdata = dword(0); dn_in.tkeep = '1; dn_in.tlast = 0;
    cyc();
    dn_in.tvalid = 0;
    #1;
    wd = dword(0);
    chk("mid_slice0", dn_out.tdata, wd[127:0]);
    cyc();
    rst_n = 0;
    dn_in.tvalid = 1; dn_in.tdata = dword(1);
    #1;
    chk("mid_slice1", dn_out.tdata, wd[255:128]);
    cyc();
    chk("mid_rst_tvalid", dn_out.tvalid, 0);
    chk("mid_rst_tready", dn_in.tready, 0);
    chk("mid_rst_tdata", dn_out.tdata, 0);
    cyc();
    rst_n = 1; dn_in.tvalid = 0;
    #1;
    chk("mid_no_stale", dn_out.tvalid, 0);
    cyc();
    chk("mid_no_stale2", dn_out.tvalid, 0);
    dn_in.tvalid = 1; dn_in.tdata = dword(2); dn_in.tlast = 1;
    cyc();
    dn_in.tvalid = 0;
    #1;
    wd = dword(2);
    chk("mid_new_v", dn_out.tvalid, 1);
    chk("mid_new_slice0", dn_out.tdata, wd[127:0]);
    cyc(); cyc(); cyc(); cyc();
    chk("mid_new_done", dn_out.tvalid, 0);

    // Upsize: six beats, tlast on the sixth.
    up_out.tready = 1;
    for (int c = 0; c <= 7; c++) begin
      up_in.tvalid = (c < 6);
      up_in.tdata  = bdat(c);
      up_in.tkeep  = 8'hFF;
      up_in.tlast  = (c == 5);
      #1;
      if (c < 6) chk("up_tready", up_in.tready, 1);
      if (c == 4) begin
        chk("up_w1_v", up_out.tvalid, 1);
        chk("up_w1", {up_out.tlast, up_out.tkeep, up_out.tdata},
            {1'b0, 32'hFFFF_FFFF, bdat(3), bdat(2), bdat(1), bdat(0)});
      end else if (c == 6) begin
        chk("up_w2_v", up_out.tvalid, 1);
        chk("up_w2", {up_out.tlast, up_out.tkeep, up_out.tdata},
            {1'b1, 32'h0000_FFFF, 128'h0, bdat(5), bdat(4)});
      end else chk("up_gap", up_out.tvalid, 0);
      cyc();
    end

    // Upsize under backpressure with gappy input; outputs must hold while stalled.
    bp_exp[0] = {1'b0, 32'hFFFF_FFFF, bdat(3), bdat(2), bdat(1), bdat(0)};
    bp_exp[1] = {1'b1, 32'h0000_00FF, 192'h0, bdat(4)};
    bp_exp[2] = {1'b1, 32'h00FF_FFFF, 64'h0, bdat(7), bdat(6), bdat(5)};
    bi = 0; oi = 0; stalled = 0; prev = '0;
    for (int c = 0; c < 80; c++) begin
      up_in.tvalid  = vpat[c%16] && (bi < 8);
      up_in.tdata   = bdat(bi);
      up_in.tkeep   = 8'hFF;
      up_in.tlast   = (bi == 4 || bi == 7);
      up_out.tready = rpat[c%16];
      #1;
      if (stalled)
        chk("bp_stable", {up_out.tvalid, up_out.tlast, up_out.tkeep, up_out.tdata}, prev);
      stalled = up_out.tvalid && !up_out.tready;
      prev    = {up_out.tvalid, up_out.tlast, up_out.tkeep, up_out.tdata};
      if (up_out.tvalid && up_out.tready) begin
        if (oi < 3) chk("bp_word", {up_out.tlast, up_out.tkeep, up_out.tdata}, bp_exp[oi]);
        oi++;
      end
      if (up_in.tvalid && up_in.tready) bi++;
      cyc();
    end
    chk("bp_word_count", oi, 3);
    up_in.tvalid = 0;

    // Pass-through: 100 random beats, one-cycle latency at full rate.
    p1_out.tready = 1;
    for (int c = 0; c <= 100; c++) begin
      if (c < 100) begin
        p1_in.tvalid = 1;
        for (int j = 0; j < 8; j++) p1_in.tdata[j*32 +: 32] = $urandom;
        p1_in.tkeep = $urandom;
        p1_in.tlast = 1'($urandom_range(0, 1));
        p1_exp[c] = {p1_in.tlast, p1_in.tkeep, p1_in.tdata};
      end else p1_in.tvalid = 0;
      #1;
      if (c < 100) chk("p1_tready", p1_in.tready, 1);
      if (c > 0) begin
        chk("p1_tvalid", p1_out.tvalid, 1);
        chk("p1_beat", {p1_out.tlast, p1_out.tkeep, p1_out.tdata}, p1_exp[c-1]);
      end
      cyc();
    end
    chk("p1_done", p1_out.tvalid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
